// File: rtl/direct_mapped_cache_ctrl_pkg.sv
// Shared types and default geometry for the direct-mapped write-through cache controller.
package direct_mapped_cache_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE_THRU, RESPOND} state_e;

  localparam int DEF_ADDR_WIDTH = 28;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_INDEX_BITS = 4;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int DEF_TAG_BITS   = DEF_ADDR_WIDTH - DEF_INDEX_BITS;
  localparam int DEF_LINES      = 1 << DEF_INDEX_BITS;
endpackage

// File: rtl/direct_mapped_cache_ctrl_if.sv
// Word-wide req/ack bus, used for both the CPU side and the memory side of the cache.
interface direct_mapped_cache_ctrl_if
  import direct_mapped_cache_ctrl_pkg::*;
#(
  parameter int AW = DEF_ADDR_WIDTH,
  parameter int DW = DEF_DATA_WIDTH
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/direct_mapped_cache_ctrl_line_store.sv
// Line storage: tag/data arrays plus valid vector, one write port, combinational read.
module cache_line_store #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 24,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] idx,
  input  logic [TAG_BITS-1:0]   wtag,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rvalid,
  output logic [TAG_BITS-1:0]   rtag,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES];

  // Only valid bits need reset; stale tag/data are masked by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   valid <= '0;
    else if (clr) valid <= '0;
    else if (we)  valid[idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[idx]  <= wtag;
      data_mem[idx] <= wdata;
    end
  end

  assign rvalid = valid[idx];
  assign rtag   = tag_mem[idx];
  assign rdata  = data_mem[idx];
endmodule

// File: rtl/direct_mapped_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with hit/miss statistics.
module direct_mapped_cache_ctrl
  import direct_mapped_cache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  direct_mapped_cache_ctrl_if.slave  cpu,
  direct_mapped_cache_ctrl_if.master mem,
  output logic [CNT_WIDTH-1:0]   hit_cnt,
  output logic [CNT_WIDTH-1:0]   miss_cnt
);
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS;

  state_e                state;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag, line_tag;
  logic [DATA_WIDTH-1:0] line_data, ls_wdata;
  logic                  line_valid, hit, accept, ls_we, ls_clr;

  assign idx = cpu.addr[INDEX_BITS-1:0];
  assign tag = cpu.addr[ADDR_WIDTH-1:INDEX_BITS];
  assign hit = line_valid && (line_tag == tag);

  // cpu.ack high means the requester has not yet dropped req for the finished access.
  assign accept   = (state == IDLE) && !flush && cpu.req && !cpu.ack;
  assign ls_clr   = (state == IDLE) && flush;
  assign ls_we    = (accept && cpu.we && hit) || (state == REFILL && mem.ack);
  assign ls_wdata = (state == REFILL) ? mem.rdata : cpu.wdata;

  cache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_store (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (ls_clr),
    .we     (ls_we),
    .idx    (idx),
    .wtag   (tag),
    .wdata  (ls_wdata),
    .rvalid (line_valid),
    .rtag   (line_tag),
    .rdata  (line_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cpu.ack   <= 1'b0;
      cpu.rdata <= '0;
      mem.req   <= 1'b0;
      mem.we    <= 1'b0;
      mem.addr  <= '0;
      mem.wdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      cpu.ack <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
          end else if (accept) begin
            if (cpu.we) begin
              mem.req   <= 1'b1;
              mem.we    <= 1'b1;
              mem.addr  <= cpu.addr;
              mem.wdata <= cpu.wdata;
              state     <= WRITE_THRU;
            end else if (hit) begin
              cpu.rdata <= line_data;
              if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
              state <= RESPOND;
            end else begin
              mem.req  <= 1'b1;
              mem.we   <= 1'b0;
              mem.addr <= cpu.addr;
              if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
              state <= REFILL;
            end
          end
        end
        REFILL: begin
          if (mem.ack) begin
            cpu.rdata <= mem.rdata;
            mem.req   <= 1'b0;
            state     <= RESPOND;
          end
        end
        WRITE_THRU: begin
          if (mem.ack) begin
            mem.req <= 1'b0;
            mem.we  <= 1'b0;
            state   <= RESPOND;
          end
        end
        RESPOND: begin
          cpu.ack <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_direct_mapped_cache_ctrl.sv
// Bench for direct_mapped_cache_ctrl: vector table driven through a scoreboard, behavioural RAM responder.
module tb_direct_mapped_cache_ctrl;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] hit_cnt, miss_cnt;

  direct_mapped_cache_ctrl_if #(.AW(AW), .DW(DW)) cpu_if ();
  direct_mapped_cache_ctrl_if #(.AW(AW), .DW(DW)) mem_if ();

  always #5 clk = ~clk;

  direct_mapped_cache_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .INDEX_BITS (4),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .cpu      (cpu_if),
    .mem      (mem_if),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;
  int mem_lat = 3;
  logic [DW-1:0] mem_store [logic [AW-1:0]];

  typedef struct {
    logic [DW-1:0] rdata;
    bit            we;
    int            h;
    int            m;
    bit            mem_op;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
    bit            exp_mem;
    int            exp_h;
    int            exp_m;
    int            exp_lat;
    int            fl_at;
  } vec_t;
  vec_t vt[$];

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return 32'h1000_0000 + {4'h0, a} + 32'h1E;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // RAM model: ack after mem_lat cycles of held req, one-cycle pulse.
  initial begin
    int cnt;
    cnt = 0;
    mem_if.ack   = 1'b0;
    mem_if.rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_if.ack) mem_if.ack = 1'b0;
      else if (mem_if.req) begin
        if (cnt >= mem_lat - 1) begin
          cnt = 0;
          mem_if.ack = 1'b1;
          if (mem_if.we) mem_store[mem_if.addr] = mem_if.wdata;
          else           mem_if.rdata = rd(mem_if.addr);
        end else cnt++;
      end else cnt = 0;
    end
  end

  task automatic do_op(input vec_t v, input int idx);
    exp_t e;
    int   cyc;
    bit   seen_mem, done;
    @(negedge clk);
    e.rdata = v.exp_rd; e.we = v.we; e.h = v.exp_h; e.m = v.exp_m; e.mem_op = v.exp_mem;
    sb.push_back(e);
    cpu_if.req = 1'b1; cpu_if.we = v.we; cpu_if.addr = v.addr; cpu_if.wdata = v.wdata;
    flush = (v.fl_at == 0);
    cyc = 0; seen_mem = 1'b0; done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      flush = (v.fl_at == cyc);
      if (mem_if.req) seen_mem = 1'b1;
      if (cpu_if.ack) done = 1'b1;
    end
    flush = 1'b0;
    cpu_if.req = 1'b0;
    e = sb.pop_front();
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL v%0d ack_timeout: got no ack expected ack within 200 cycles", idx);
    end else begin
      if (!e.we) chk($sformatf("v%0d rdata", idx), 64'(cpu_if.rdata), 64'(e.rdata));
      chk($sformatf("v%0d hit_cnt", idx), 64'(hit_cnt), 64'(e.h));
      chk($sformatf("v%0d miss_cnt", idx), 64'(miss_cnt), 64'(e.m));
      chk($sformatf("v%0d mem_req", idx), 64'(seen_mem), 64'(e.mem_op));
      if (v.exp_lat >= 0) chk($sformatf("v%0d latency", idx), 64'(cyc), 64'(v.exp_lat));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected end before 200us");
    $fatal(1);
  end

  initial begin
    int w;
    //              we addr          wdata          exp_rd         mem h  m  lat fl
    vt.push_back(vec_t'{0, 28'h100,     32'h0,        32'h1000011E, 1, 0, 1, -1, -1});
    vt.push_back(vec_t'{0, 28'h100,     32'h0,        32'h1000011E, 0, 1, 1,  2, -1});
    vt.push_back(vec_t'{0, 28'h102,     32'h0,        32'h10000120, 1, 1, 2, -1, -1});
    vt.push_back(vec_t'{1, 28'h102,     32'h00000120, 32'h0,        1, 1, 2, -1, -1});
    vt.push_back(vec_t'{0, 28'h102,     32'h0,        32'h00000120, 0, 2, 2,  2, -1});
    vt.push_back(vec_t'{1, 28'h200,     32'hDEADBEEF, 32'h0,        1, 2, 2, -1, -1});
    vt.push_back(vec_t'{0, 28'h200,     32'h0,        32'hDEADBEEF, 1, 2, 3, -1, -1});
    vt.push_back(vec_t'{0, 28'h0,       32'h0,        32'h1000001E, 1, 2, 3, -1, -1});
    vt.push_back(vec_t'{0, 28'hFFFFFFF, 32'h0,        32'h2000001D, 1, 2, 3, -1, -1});
    vt.push_back(vec_t'{0, 28'hFFFFFFF, 32'h0,        32'h2000001D, 0, 3, 3,  2, -1});
    vt.push_back(vec_t'{0, 28'h0,       32'h0,        32'h1000001E, 0, 3, 3,  2, -1});
    vt.push_back(vec_t'{0, 28'h100,     32'h0,        32'h1000011E, 1, 0, 1, -1,  0});
    vt.push_back(vec_t'{0, 28'h110,     32'h0,        32'h1000012E, 1, 0, 2, -1, -1});
    vt.push_back(vec_t'{0, 28'h100,     32'h0,        32'h1000011E, 1, 0, 3, -1, -1});
    vt.push_back(vec_t'{0, 28'hFFFFFFF, 32'h0,        32'h2000001D, 1, 0, 3, -1, -1});
    vt.push_back(vec_t'{0, 28'h202,     32'h0,        32'h10000220, 1, 0, 3, -1,  1});
    for (int i = 1; i <= 5; i++)
      vt.push_back(vec_t'{0, 28'h202, 32'h0, 32'h10000220, 0, (i > 3) ? 3 : i, 3, 2, -1});

    cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset mem_req", 64'(mem_if.req), 64'd0);
    chk("reset cpu_ack", 64'(cpu_if.ack), 64'd0);
    chk("reset cpu_rdata", 64'(cpu_if.rdata), 64'd0);
    chk("reset mem_addr", 64'(mem_if.addr), 64'd0);
    chk("reset hit_cnt", 64'(hit_cnt), 64'd0);
    chk("reset miss_cnt", 64'(miss_cnt), 64'd0);
    rst_n = 1'b1;

    // Reset while a refill is outstanding: mem_req must drop without a clock edge.
    mem_lat = 50;
    @(negedge clk);
    cpu_if.req = 1'b1; cpu_if.addr = 28'h300;
    w = 0;
    while (!mem_if.req && w < 10) begin @(negedge clk); w++; end
    chk("refill mem_req", 64'(mem_if.req), 64'd1);
    chk("refill miss_cnt", 64'(miss_cnt), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst mem_req", 64'(mem_if.req), 64'd0);
    chk("async rst miss_cnt", 64'(miss_cnt), 64'd0);
    chk("async rst hit_cnt", 64'(hit_cnt), 64'd0);
    cpu_if.req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_lat = 3;

    foreach (vt[i]) do_op(vt[i], i);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
